hazard_ctrl: RTL and testbench



---
 rtl/riscv_pkg.sv | 25 ++
 rtl/hazard_shadow_pipe.sv | 39 +++
 rtl/hazard_ctrl.sv | 109 ++++++++++
 tb/tb_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V core: forwarding selects, hazard shadow slots
// and the register-match helper used by the hazard controller.
package riscv_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } hz_slot_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // True when the slot will write a real register that this source reads.
    function automatic logic slot_match(hz_slot_t s, logic [4:0] rs, logic uses);
        return s.valid && s.reg_write && (s.rd != REG_X0) && (s.rd == rs) && uses;
    endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Three-slot shadow of the EX/MEM/WB destination state; the entry leaving ID
// is replaced by an invalid slot when a bubble is inserted into EX.
module hazard_shadow_pipe
    import riscv_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  hz_slot_t i_id_entry,
    input  logic     i_bubble,
    output hz_slot_t o_ex,
    output hz_slot_t o_mem,
    output hz_slot_t o_wb
);

    hz_slot_t r_ex, r_mem, r_wb;
    hz_slot_t w_ex_next;

    always_comb begin
        w_ex_next = i_id_entry;
        if (i_bubble) w_ex_next.valid = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_ex  <= w_ex_next;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    assign o_ex  = r_ex;
    assign o_mem = r_mem;
    assign o_wb  = r_wb;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW stalls, taken-branch flush,
// operand forwarding selects and saturating stall/flush counters.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int FORWARDING = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_branch_taken,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_slot_t w_id_entry, w_ex, w_mem, w_wb;
    logic     w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2, w_wb_m1, w_wb_m2;
    logic     w_load_use, w_raw, w_hazard;
    fwd_sel_t w_fwd_a, w_fwd_b;

    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    assign w_id_entry = '{valid: id_valid, rd: id_rd,
                          reg_write: id_reg_write, mem_read: id_mem_read};

    hazard_shadow_pipe u_shadow (
        .clk        (clk),
        .rst        (rst),
        .i_id_entry (w_id_entry),
        .i_bubble   (bubble_ex),
        .o_ex       (w_ex),
        .o_mem      (w_mem),
        .o_wb       (w_wb)
    );

    assign w_ex_m1  = slot_match(w_ex,  id_rs1, id_uses_rs1);
    assign w_ex_m2  = slot_match(w_ex,  id_rs2, id_uses_rs2);
    assign w_mem_m1 = slot_match(w_mem, id_rs1, id_uses_rs1);
    assign w_mem_m2 = slot_match(w_mem, id_rs2, id_uses_rs2);
    assign w_wb_m1  = slot_match(w_wb,  id_rs1, id_uses_rs1);
    assign w_wb_m2  = slot_match(w_wb,  id_rs2, id_uses_rs2);

    assign w_load_use = w_ex.mem_read && (w_ex_m1 || w_ex_m2);
    assign w_raw      = w_ex_m1 || w_ex_m2 || w_mem_m1 || w_mem_m2 || w_wb_m1 || w_wb_m2;
    assign w_hazard   = id_valid && ((FORWARDING != 0) ? w_load_use : w_raw);

    // A load sitting in MEM has no data yet; the load-use stall keeps it out of reach.
    function automatic fwd_sel_t pick_fwd(logic mem_m, logic wb_m);
        if (mem_m && !w_mem.mem_read) return FWD_MEM;
        if (wb_m)                     return FWD_WB;
        return FWD_RF;
    endfunction

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        w_fwd_a   = FWD_RF;
        w_fwd_b   = FWD_RF;
        if (!rst) begin
            if (ex_branch_taken) begin
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (w_hazard) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
            if (FORWARDING != 0) begin
                w_fwd_a = pick_fwd(w_mem_m1, w_wb_m1);
                w_fwd_b = pick_fwd(w_mem_m2, w_wb_m2);
            end
        end
    end

    assign fwd_a = w_fwd_a;
    assign fwd_b = w_fwd_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_id && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (flush_id && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a forwarding instance and a no-forwarding instance
// (narrow counters) share stimulus and are checked against a reference model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, br;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic [1:0]  s_if, s_id, fl, bub;
    logic [1:0]  fa0, fb0, fa1, fb1;
    logic [31:0] sc0, fc0;
    logic [3:0]  sc1, fc1;

    hazard_ctrl #(.FORWARDING(1), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(br),
        .stall_if(s_if[0]), .stall_id(s_id[0]), .flush_id(fl[0]), .bubble_ex(bub[0]),
        .fwd_a(fa0), .fwd_b(fb0), .stall_count(sc0), .flush_count(fc0));

    hazard_ctrl #(.FORWARDING(0), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(br),
        .stall_if(s_if[1]), .stall_id(s_id[1]), .flush_id(fl[1]), .bubble_ex(bub[1]),
        .fwd_a(fa1), .fwd_b(fb1), .stall_count(sc1), .flush_count(fc1));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw;
        bit       ld;
    } instr_t;

    instr_t  pipe [2][3];
    longint  cs [2], cf [2];
    longint  cmax [2] = '{64'hFFFF_FFFF, 64'd15};
    int      fwd_on [2] = '{1, 0};

    logic [7:0]  g_haz [2];
    logic [31:0] g_sc [2], g_fc [2];

    function automatic bit writes(int d, int k, logic [4:0] rs, logic uses);
        return pipe[d][k].v && pipe[d][k].rw && pipe[d][k].rd != 0 && pipe[d][k].rd == rs && uses;
    endfunction

    function automatic logic [1:0] fwd_model(int d, logic [4:0] rs, logic uses);
        if (fwd_on[d] == 0) return 2'b00;
        if (writes(d, 1, rs, uses) && !pipe[d][1].ld) return 2'b10;
        if (writes(d, 2, rs, uses)) return 2'b01;
        return 2'b00;
    endfunction

    // Packed as {stall_if, stall_id, flush_id, bubble_ex, fwd_a, fwd_b}.
    function automatic logic [7:0] expect_out(int d);
        bit hz = 0;
        logic [7:0] e = 8'h00;
        if (rst) return 8'h00;
        if (fwd_on[d] != 0)
            hz = pipe[d][0].ld && (writes(d, 0, id_rs1, id_uses_rs1) || writes(d, 0, id_rs2, id_uses_rs2));
        else
            for (int k = 0; k < 3; k++)
                hz |= writes(d, k, id_rs1, id_uses_rs1) || writes(d, k, id_rs2, id_uses_rs2);
        hz &= id_valid;
        if (br)      e[7:4] = 4'b0011;
        else if (hz) e[7:4] = 4'b1101;
        e[3:2] = fwd_model(d, id_rs1, id_uses_rs1);
        e[1:0] = fwd_model(d, id_rs2, id_uses_rs2);
        return e;
    endfunction

    function automatic logic [7:0] got_out(int d);
        return {s_if[d], s_id[d], fl[d], bub[d], (d == 0) ? fa0 : fa1, (d == 0) ? fb0 : fb1};
    endfunction

    task automatic step();
        logic [7:0] e [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            e[d]    = expect_out(d);
            g_haz[d] = got_out(d);
            g_sc[d]  = (d == 0) ? sc0 : {28'd0, sc1};
            g_fc[d]  = (d == 0) ? fc0 : {28'd0, fc1};
            chk(d == 0 ? "haz_fw1" : "haz_fw0", g_haz[d], e[d]);
            chk(d == 0 ? "scnt_fw1" : "scnt_fw0", g_sc[d], cs[d]);
            chk(d == 0 ? "fcnt_fw1" : "fcnt_fw0", g_fc[d], cf[d]);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int k = 0; k < 3; k++) pipe[d][k] = '{0, 0, 0, 0};
                cs[d] = 0;
                cf[d] = 0;
            end else begin
                pipe[d][2] = pipe[d][1];
                pipe[d][1] = pipe[d][0];
                pipe[d][0] = '{id_valid && !e[d][4], id_rd, id_reg_write, id_mem_read};
                if (e[d][6] && cs[d] < cmax[d]) cs[d]++;
                if (e[d][5] && cf[d] < cmax[d]) cf[d]++;
            end
        end
        #1;
    endtask

    task automatic set_id(logic v, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                          logic u1, logic u2, logic rw, logic ld);
        id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_reg_write = rw; id_mem_read = ld;
    endtask

    task automatic do_reset();
        rst = 1'b1; br = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) pipe[d][k] = '{0, 0, 0, 0};
            cs[d] = 0; cf[d] = 0;
        end
        rst = 1'b1; br = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        br = 1'b1;
        set_id(1, 3, 3, 3, 1, 1, 1, 1);
        step();
        chk("rst_forced_fw1", g_haz[0], 8'h00);
        chk("rst_forced_fw0", g_haz[1], 8'h00);
        do_reset();

        // back-to-back ALU ops: forwarding covers everything, never stalls
        set_id(1, 3, 1, 2, 1, 1, 1, 0); step();
        set_id(1, 4, 3, 3, 1, 1, 1, 0); step();
        set_id(1, 8, 3, 4, 1, 1, 1, 0); step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("b2b_no_stall_cnt", g_sc[0], 0);

        // x0 writer and unused-source reader
        do_reset();
        set_id(1, 0, 0, 0, 1, 0, 1, 0); step();
        set_id(1, 9, 0, 0, 1, 1, 1, 0); step();
        chk("x0_fw1", g_haz[0], 8'h00);
        chk("x0_fw0", g_haz[1], 8'h00);
        set_id(1, 12, 1, 1, 1, 0, 1, 0); step();
        set_id(1, 13, 1, 12, 1, 0, 1, 0); step();
        chk("unused_rs2_fw1", g_haz[0], 8'h00);
        chk("unused_rs2_fw0", g_haz[1], 8'h00);

        // load-use: one stall, then operand from WB once the load reaches it
        do_reset();
        set_id(1, 5, 1, 0, 1, 0, 1, 1); step();
        set_id(1, 6, 5, 7, 1, 1, 1, 0); step();
        chk("lu_stall", g_haz[0], 8'hD0);
        step();
        chk("lu_release", g_haz[0], 8'h00);
        step();
        chk("lu_fwd_wb", g_haz[0], 8'h04);
        chk("lu_stall_cnt", g_sc[0], 1);

        // branch beats a simultaneous load-use
        do_reset();
        set_id(1, 5, 1, 0, 1, 0, 1, 1); step();
        set_id(1, 6, 5, 7, 1, 1, 1, 0); br = 1'b1; step();
        chk("br_wins", g_haz[0], 8'h30);
        chk("br_fcnt_before", g_fc[0], 0);
        br = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("br_fcnt_after", g_fc[0], 1);

        // no forwarding: RAW on the previous instruction stalls three cycles
        do_reset();
        set_id(1, 3, 1, 2, 1, 1, 1, 0); step();
        set_id(1, 4, 3, 3, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("raw_stall", g_haz[1], 8'hD0);
        end
        step();
        chk("raw_release", g_haz[1], 8'h00);
        chk("raw_stall_cnt", g_sc[1], 3);

        // reset in the middle of a RAW stall
        do_reset();
        set_id(1, 3, 1, 2, 1, 1, 1, 0); step();
        set_id(1, 4, 3, 3, 1, 1, 1, 0); step(); step();
        rst = 1'b1; step();
        chk("midrst_forced", g_haz[1], 8'h00);
        rst = 1'b0; step();
        chk("midrst_after", g_haz[1], 8'h00);
        chk("midrst_cnt", g_sc[1], 0);

        // random traffic over a few registers so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            br  = ($urandom_range(0, 7) == 0);
            set_id($urandom_range(0, 4) != 0, 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
